// File: rtl/imem_loader_if.sv
// Byte-stream side and instruction-memory write side of the loader.
// Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
// byte_data must be stable while byte_valid is high, and byte_valid may drop at any time.
interface imem_loader_if;
    logic        start;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        abort;
    logic        byte_ready;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, word_count, byte_valid, byte_data, abort,
        input  byte_ready, load_we, load_addr, load_data, busy, cpu_hold, done, error
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data, abort,
        output byte_ready, load_we, load_addr, load_data, busy, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory from address 0 upward, holding the core while it does so.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  word_idx_q, word_idx_d;
    logic [6:0]  count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        error_q, error_d;
    logic        start_ok;
    logic        busy;

    assign start_ok  = (bus.word_count != 7'd0) && ({25'd0, bus.word_count} <= 32'(DEPTH));
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_ok) begin
                        count_d    = bus.word_count;
                        word_idx_d = 7'd0;
                        byte_idx_d = 2'd0;
                        asm_d      = 32'd0;
                        state_d    = RECV;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // abort outranks a byte arriving in the same cycle; the partial word is dropped
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.byte_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    word_idx_d = word_idx_q + 7'd1;
                    state_d    = (word_idx_q == count_q - 7'd1) ? DONE : RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_idx_q <= 7'd0;
            count_q    <= 7'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            error_q    <= error_d;
        end
    end

    // Outputs are forced quiet while reset is held, before the state register settles.
    always_comb begin
        busy           = 1'b0;
        bus.byte_ready = 1'b0;
        bus.load_we    = 1'b0;
        bus.load_addr  = 32'd0;
        bus.load_data  = 32'd0;
        bus.done       = 1'b0;
        bus.error      = 1'b0;
        if (!reset) begin
            busy           = (state_q == RECV) || (state_q == WRITE);
            bus.byte_ready = (state_q == RECV);
            bus.done       = (state_q == DONE);
            bus.error      = error_q;
            if (state_q == WRITE) begin
                bus.load_we   = !bus.abort;
                bus.load_addr = {23'd0, word_idx_q, 2'b00};
                bus.load_data = asm_q;
            end
        end
        bus.busy     = busy;
        bus.cpu_hold = busy;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of load scenarios plus hand-written
// sequences for the exact-byte, stall, reset and ignored-start cases.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    imem_loader_if bus();

    imem_loader #(.DEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int ready_drops = 0;
    int last_accept_cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  src[$];

    typedef struct {
        logic [6:0] wc;
        int         nbytes;
        int         stall;
        int         abort_after;
        int         exp_writes;
        int         exp_done;
        int         exp_err;
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.byte_valid && bus.byte_ready) last_accept_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.error) err_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.load_we) begin
            last_we_cyc = cyc;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("write", {bus.load_addr, bus.load_data}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] wc);
        bus.start = 1'b1;
        bus.word_count = wc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        while (!bus.byte_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) fail_now("byte_ready_timeout");
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (dbg_state != 2'd0 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) fail_now("idle_timeout");
    endtask

    task automatic push_expected(input int n);
        for (int w = 0; w < n; w++)
            exp_q.push_back({32'(w * 4), src[4*w+3], src[4*w+2], src[4*w+1], src[4*w]});
    endtask

    task automatic run_load(input logic [6:0] wc, input int nbytes, input int stall,
                            input int abort_after, input bit check_ready);
        do_start(wc);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(src[i]);
            if (abort_after == i + 1) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                check("abort_idle_busy", 64'(bus.busy), 64'd0);
                return;
            end
            for (int s = 0; s < stall; s++) begin
                tick();
                if (check_ready && (i % 4) != 3 && !bus.byte_ready) ready_drops++;
            end
        end
        wait_idle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, b0;
        bus.start = 1'b0;
        bus.word_count = 7'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'd0;
        bus.abort = 1'b0;

        tick();
        tick();
        check("rst_ctl", 64'({bus.byte_ready, bus.load_we, bus.busy, bus.cpu_hold, bus.done, bus.error}), 64'd0);
        check("rst_bus", {bus.load_addr, bus.load_data}, 64'd0);
        reset = 1'b0;
        check("post_rst_ctl", 64'({bus.byte_ready, bus.load_we, bus.busy, bus.cpu_hold, bus.done, bus.error}), 64'd0);
        check("post_rst_bus", {bus.load_addr, bus.load_data}, 64'd0);
        tick();

        vt[0] = '{7'd0,   0,   0, 0,  0,  0, 1};
        vt[1] = '{7'd65,  0,   0, 0,  0,  0, 1};
        vt[2] = '{7'd127, 0,   0, 0,  0,  0, 1};
        vt[3] = '{7'd1,   4,   0, 0,  1,  1, 0};
        vt[4] = '{7'd2,   8,   2, 0,  2,  1, 0};
        vt[5] = '{7'd3,   12,  0, 6,  1,  0, 0};
        vt[6] = '{7'd2,   8,   0, 4,  0,  0, 0};
        vt[7] = '{7'd64,  256, 0, 0,  64, 1, 0};
        vt[8] = '{7'd4,   16,  1, 15, 3,  0, 0};

        for (int r = 0; r < NV; r++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            b0 = busy_cnt;
            src.delete();
            for (int i = 0; i < vt[r].nbytes; i++) src.push_back(8'(i * 37 + r * 11 + 5));
            push_expected(vt[r].exp_writes);
            run_load(vt[r].wc, vt[r].nbytes, vt[r].stall, vt[r].abort_after, 1'b0);
            tick();
            tick();
            check($sformatf("row%0d_outstanding", r), 64'(exp_q.size()), 64'd0);
            check($sformatf("row%0d_done", r), 64'(done_cnt - d0), 64'(vt[r].exp_done));
            check($sformatf("row%0d_error", r), 64'(err_cnt - e0), 64'(vt[r].exp_err));
            if (vt[r].exp_err != 0) check($sformatf("row%0d_busy", r), 64'(busy_cnt - b0), 64'd0);
            if (vt[r].exp_done != 0) check($sformatf("row%0d_done_lat", r), 64'(done_cyc - last_we_cyc), 64'd1);
            exp_q.delete();
        end

        // Exact two-word program, back-to-back bytes.
        src.delete();
        src = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
        exp_q.push_back({32'h0, 32'h00500113});
        exp_q.push_back({32'h4, 32'h00C00193});
        d0 = done_cnt;
        run_load(7'd2, 8, 0, 0, 1'b0);
        tick();
        check("prog_outstanding", 64'(exp_q.size()), 64'd0);
        check("prog_done", 64'(done_cnt - d0), 64'd1);
        check("prog_we_lat", 64'(last_we_cyc - last_accept_cyc), 64'd1);
        check("prog_done_lat", 64'(done_cyc - last_we_cyc), 64'd1);

        // Same program with three idle cycles between every byte.
        exp_q.push_back({32'h0, 32'h00500113});
        exp_q.push_back({32'h4, 32'h00C00193});
        d0 = done_cnt;
        ready_drops = 0;
        run_load(7'd2, 8, 3, 0, 1'b1);
        tick();
        check("stall_outstanding", 64'(exp_q.size()), 64'd0);
        check("stall_done", 64'(done_cnt - d0), 64'd1);
        check("stall_ready_held", 64'(ready_drops), 64'd0);
        check("stall_we_lat", 64'(last_we_cyc - last_accept_cyc), 64'd1);

        // Reset mid-word, then a fresh one-word load.
        do_start(7'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        tick();
        check("midrst_ctl", 64'({bus.byte_ready, bus.load_we, bus.busy, bus.cpu_hold, bus.done, bus.error}), 64'd0);
        tick();
        reset = 1'b0;
        check("midrst_bus", {bus.load_addr, bus.load_data}, 64'd0);
        tick();
        src.delete();
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q.push_back({32'h0, 32'h04030201});
        d0 = done_cnt;
        run_load(7'd1, 4, 0, 0, 1'b0);
        tick();
        check("midrst_outstanding", 64'(exp_q.size()), 64'd0);
        check("midrst_done", 64'(done_cnt - d0), 64'd1);

        // A start arriving mid-load must not restart or resize it.
        src.delete();
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back({32'h0, 32'h44332211});
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(7'd1);
        send_byte(src[0]);
        bus.start = 1'b1;
        bus.word_count = 7'd3;
        tick();
        bus.start = 1'b0;
        send_byte(src[1]);
        send_byte(src[2]);
        send_byte(src[3]);
        wait_idle();
        tick();
        check("ign_start_outstanding", 64'(exp_q.size()), 64'd0);
        check("ign_start_done", 64'(done_cnt - d0), 64'd1);
        check("ign_start_error", 64'(err_cnt - e0), 64'd0);
        check("ign_start_idle", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the target instruction memory.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-005 word_count  input  7  number of words to load; latched on accepted start.
REQ-006 byte_valid  input  1  incoming byte available.
REQ-007 byte_data  input  8  incoming byte; little-endian within each word.
REQ-008 abort  input  1  terminate an in-progress load.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 load_we  output  1  write strobe to the instruction-memory write port.
REQ-011 load_addr  output  32  byte address of the write; always word-aligned (bits [1:0]=0).
REQ-012 load_data  output  32  instruction word being written.
REQ-013 busy  output  1  high in RECV and WRITE.
REQ-014 cpu_hold  output  1  equals busy; holds the core in reset while memory is rewritten.
REQ-015 done  output  1  one-cycle pulse after the last word is written.
REQ-016 error  output  1  one-cycle pulse on a rejected start.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, start with 1 <= word_count <= DEPTH SHALL latch word_count, clear word_idx and byte_idx, and enter RECV on the next cycle.
REQ-019 In IDLE, start with word_count == 0 or word_count > DEPTH SHALL pulse error for one cycle, stay in IDLE and perform no write.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid && byte_ready.
REQ-022 The k-th accepted byte of a word (k=0..3) SHALL be placed in bits [8k+7:8k] of the assembly register.
REQ-023 Acceptance of byte 3 SHALL move the FSM to WRITE on the next cycle; byte_idx SHALL wrap to 0.
REQ-024 WRITE SHALL last exactly one cycle with load_we=1, load_addr = word_idx*4 and load_data = the assembled word.
REQ-025 After WRITE, word_idx SHALL increment; the FSM SHALL enter DONE if the word just written was word_count-1, and RECV otherwise.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 Latency from acceptance of the final byte of a word to load_we SHALL be exactly 1 cycle.
REQ-028 byte_valid stalls of any length in RECV SHALL preserve partial-word state.
REQ-029 abort in RECV or WRITE SHALL take priority over all other events: the FSM returns to IDLE next cycle, load_we is suppressed in that cycle, and no done pulse occurs.
REQ-030 Words already written before an abort SHALL remain in memory; the partial word SHALL be discarded.
REQ-031 load_we SHALL be 0 in every state except WRITE.

Reset
REQ-032 reset SHALL force IDLE and clear word_idx, byte_idx, the assembly register and the latched count.
REQ-033 While reset is high and on the first cycle after it is released, byte_ready, load_we, busy, cpu_hold, done and error SHALL all be 0, and load_addr and load_data SHALL both be 0.
REQ-034 reset asserted during RECV or WRITE SHALL abandon the load, with the same effect as REQ-029.

Verification
REQ-035 start, word_count=2, bytes 13 01 50 00 93 01 C0 00 sent back-to-back -> load_we at addr 0x0 with 0x00500113, then at addr 0x4 with 0x00C00193; done pulses once.
REQ-036 Same load with byte_valid low for 3 cycles between every byte -> identical writes; byte_ready stays 1 throughout the stalls.
REQ-037 start with word_count=0, then with word_count=65 -> error pulses each time; load_we never asserts; busy stays 0.
REQ-038 word_count=64, 256 bytes sent -> the last write is at addr 0xFC; done occurs 1 cycle after that write.
REQ-039 word_count=3, abort after the 6th byte -> one write at 0x0, no further load_we, no done, IDLE the next cycle.
REQ-040 reset pulsed mid-word, then a new start with word_count=1 and 4 bytes -> the single write at 0x0 contains only the new bytes.
